cache_sram_arbiter: RTL and testbench

Shares the single multi-cycle cache SRAM between the dcache controller and the icache controller. It grants one requester at a time, sequences the SRAM enables for a fixed access latency, and reports progress through the `sram_state` code (FREE/BUSY/ACCESS) that the cache controllers already test. It sits between both cache FSMs and the SRAM macro. Arbitration is round-robin.

---
 rtl/cache_sram_arbiter_if.sv | 41 ++++
 rtl/cache_sram_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_sram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_sram_arbiter_if
// Purpose  : Bundles the dcache/icache request ports and the SRAM macro port.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_sram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 64
);
  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_done;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_done;
  logic [LINE_W-1:0] rdata;
  logic [1:0]        sram_state;
  logic              sram_ren;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [LINE_W-1:0] sram_wdata;
  logic [LINE_W-1:0] sram_rdata;

  modport master (
    input  d_req, d_wen, d_addr, d_wdata, i_req, i_addr, sram_rdata,
    output d_grant, d_done, i_grant, i_done, rdata, sram_state,
           sram_ren, sram_wen, sram_addr, sram_wdata
  );

  modport slave (
    output d_req, d_wen, d_addr, d_wdata, i_req, i_addr, sram_rdata,
    input  d_grant, d_done, i_grant, i_done, rdata, sram_state,
           sram_ren, sram_wen, sram_addr, sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_sram_arbiter
// Purpose  : Round-robin owner of the multi-cycle cache SRAM for dcache/icache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_sram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 64,
  parameter int LAT    = 2
) (
  input wire                   clk,
  input wire                   rst,
  cache_sram_arbiter_if.master bus
);

  localparam int   CNT_W   = $clog2(LAT) + 1;
  localparam logic c_OWN_D = 1'b0;
  localparam logic c_OWN_I = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                w_owner_nxt;
  logic                r_last_owner;
  logic                w_last_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_latch;
  logic                w_capture;
  logic                w_win;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_rdata;
  logic                r_d_grant;
  logic                r_i_grant;
  logic                r_d_done;
  logic                r_i_done;

  // On a tie the requester that did not own the SRAM last time wins.
  assign w_win = (bus.d_req && bus.i_req) ? ~r_last_owner : bus.i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.d_req || bus.i_req) begin
          w_state_nxt = S_BUSY;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_cnt_nxt   = CNT_W'(LAT - 1);
          w_latch     = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ACCESS;
          w_capture   = ~r_wen;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= c_OWN_D;
      r_last_owner <= c_OWN_I;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_d_grant    <= 1'b0;
      r_i_grant    <= 1'b0;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_latch) begin
        r_addr  <= w_win ? bus.i_addr : bus.d_addr;
        r_wen   <= w_win ? 1'b0 : bus.d_wen;
        r_wdata <= w_win ? '0 : bus.d_wdata;
      end
      if (w_capture) begin
        r_rdata <= bus.sram_rdata;
      end
      // Grants and done are decoded from the next state so they are flop outputs.
      r_d_grant <= (w_state_nxt != S_IDLE) && (w_owner_nxt == c_OWN_D);
      r_i_grant <= (w_state_nxt != S_IDLE) && (w_owner_nxt == c_OWN_I);
      r_d_done  <= (w_state_nxt == S_ACCESS) && (w_owner_nxt == c_OWN_D);
      r_i_done  <= (w_state_nxt == S_ACCESS) && (w_owner_nxt == c_OWN_I);
    end
  end

  assign bus.d_grant    = r_d_grant;
  assign bus.i_grant    = r_i_grant;
  assign bus.d_done     = r_d_done;
  assign bus.i_done     = r_i_done;
  assign bus.rdata      = r_rdata;
  assign bus.sram_state = r_state;
  assign bus.sram_ren   = (r_state == S_BUSY) && ~r_wen;
  assign bus.sram_wen   = (r_state == S_BUSY) && r_wen;
  assign bus.sram_addr  = r_addr;
  assign bus.sram_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_sram_arbiter
// Purpose  : Scoreboard bench for cache_sram_arbiter (LAT=2 and LAT=1 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_sram_arbiter;

  localparam int ADDR_W = 8;
  localparam int LINE_W = 64;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_sram_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus  ();
  cache_sram_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus1 ();

  cache_sram_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LAT(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cache_sram_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  function automatic logic [63:0] pat(input logic [7:0] a);
    return 64'hDEAD_BEEF_0000_0000 | {56'h0, a};
  endfunction

  // SRAM model: rows hold pat(addr) until written.
  logic [255:0] sram_vld;
  logic [63:0]  sram_mem [256];
  always @(posedge clk) begin
    if (rst) sram_vld <= '0;
    else if (bus.sram_wen) begin
      sram_vld[bus.sram_addr] <= 1'b1;
      sram_mem[bus.sram_addr] <= bus.sram_wdata;
    end
  end
  assign bus.sram_rdata  = !bus.sram_ren ? 64'h0BAD_0BAD_0BAD_0BAD :
                           sram_vld[bus.sram_addr] ? sram_mem[bus.sram_addr] : pat(bus.sram_addr);
  assign bus1.sram_rdata = !bus1.sram_ren ? 64'h0BAD_0BAD_0BAD_0BAD : pat(bus1.sram_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] dq[$];
  logic [63:0] iq[$];
  logic [63:0] iq1[$];
  int          order_q[$];
  logic [63:0] ref_mem [logic [7:0]];
  logic [63:0] model_rd = '0;
  int          t_d_done = 0;
  int          t_i_done = 0;
  int          spurious = 0;
  int          both_cnt = 0;

  function automatic logic [63:0] ref_rd(input logic [7:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic void push_d(input logic wen, input logic [7:0] a, input logic [63:0] wd);
    if (wen) ref_mem[a] = wd;
    else     model_rd   = ref_rd(a);
    dq.push_back(model_rd);
  endfunction

  always @(negedge clk) begin
    if (bus.d_done) begin
      order_q.push_back(0);
      t_d_done = cyc;
      if (dq.size() == 0) spurious++;
      else check("d_rdata", bus.rdata, dq.pop_front());
    end
    if (bus.i_done) begin
      order_q.push_back(1);
      t_i_done = cyc;
      if (iq.size() == 0) spurious++;
      else check("i_rdata", bus.rdata, iq.pop_front());
    end
    if (bus1.i_done) begin
      if (iq1.size() == 0) spurious++;
      else check("i1_rdata", bus1.rdata, iq1.pop_front());
    end
    if (bus1.d_done) spurious++;
    if (bus.d_grant && bus.i_grant) both_cnt++;
  end

  task automatic d_issue(input logic wen, input logic [7:0] a, input logic [63:0] wd, output int lat);
    int t0;
    bit seen;
    bus.d_wen = wen; bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
    push_d(wen, a, wd);
    t0 = cyc; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = bus.d_done;
    end
    bus.d_req = 1'b0;
    if (!seen) check("d_timeout", 64'(seen), 64'd1);
    lat = cyc - t0;
    @(negedge clk);
  endtask

  task automatic i_issue(input logic [7:0] a, output int lat);
    int t0;
    bit seen;
    bus.i_addr = a; bus.i_req = 1'b1;
    model_rd = ref_rd(a);
    iq.push_back(model_rd);
    t0 = cyc; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = bus.i_done;
    end
    bus.i_req = 1'b0;
    if (!seen) check("i_timeout", 64'(seen), 64'd1);
    lat = cyc - t0;
    @(negedge clk);
  endtask

  // Single dcache access observed cycle by cycle from the request cycle.
  task automatic probe(input logic wen, input logic [7:0] a, input logic [63:0] wd,
                       output logic [9:0] seq, output int n_gnt, output int n_ren,
                       output int n_wen, output int n_done, output int done_at, output int n_bad);
    seq = '0; n_gnt = 0; n_ren = 0; n_wen = 0; n_done = 0; done_at = -1; n_bad = 0;
    bus.d_wen = wen; bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
    push_d(wen, a, wd);
    for (int s = 0; s < LAT + 3; s++) begin
      if (s > 0) @(negedge clk);
      seq = {seq[7:0], bus.sram_state};
      n_gnt += int'(bus.d_grant);
      n_ren += int'(bus.sram_ren);
      n_wen += int'(bus.sram_wen);
      if (bus.d_done) begin
        n_done++;
        done_at = s;
        bus.d_req = 1'b0;
      end
      if ((bus.sram_ren || bus.sram_wen) &&
          (bus.sram_addr != a || (bus.sram_wen && bus.sram_wdata != wd))) n_bad++;
    end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  logic [9:0] seq;
  int g, r, w, d, dat, bad, ld, li, maxlat;
  int t1[$];
  logic [5:0] ord;

  initial begin
    rst = 1'b1;
    bus.d_req = 0; bus.d_wen = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.i_req = 0; bus.i_addr = 0;
    bus1.d_req = 0; bus1.d_wen = 0; bus1.d_addr = 0; bus1.d_wdata = 0; bus1.i_req = 0; bus1.i_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(bus.sram_state), 64'd0);
    check("rst_flags", 64'({bus.d_grant, bus.i_grant, bus.d_done, bus.i_done, bus.sram_ren, bus.sram_wen}), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read of row 0x12
    probe(1'b0, 8'h12, 64'h0, seq, g, r, w, d, dat, bad);
    check("rd_state_seq", 64'(seq), 64'h058);
    check("rd_grant_cycles", 64'(g), 64'd3);
    check("rd_ren_cycles", 64'(r), 64'd2);
    check("rd_wen_cycles", 64'(w), 64'd0);
    check("rd_done_slot", 64'(dat), 64'd3);
    check("rd_bus", 64'(bad), 64'd0);

    // Write of row 0x05, then read it back
    probe(1'b1, 8'h05, 64'h1111, seq, g, r, w, d, dat, bad);
    check("wr_wen_cycles", 64'(w), 64'd2);
    check("wr_ren_cycles", 64'(r), 64'd0);
    check("wr_done_pulses", 64'(d), 64'd1);
    check("wr_bus", 64'(bad), 64'd0);
    d_issue(1'b0, 8'h05, 64'h0, ld);

    // Reset in the second BUSY cycle
    bus.d_wen = 1'b0; bus.d_addr = 8'h40; bus.d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstb_in_busy", 64'(bus.sram_state), 64'd1);
    rst = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("rstb_state", 64'(bus.sram_state), 64'd0);
    check("rstb_flags", 64'({bus.d_grant, bus.i_grant, bus.d_done, bus.i_done, bus.sram_ren, bus.sram_wen}), 64'd0);
    rst = 1'b0;
    model_rd = '0;
    ref_mem.delete();
    @(negedge clk);

    // Simultaneous requests after reset
    order_q.delete();
    fork
      d_issue(1'b0, 8'h20, 64'h0, ld);
      i_issue(8'h30, li);
    join
    check("tie_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() >= 2) begin
      check("tie_first_d", 64'(order_q[0]), 64'd0);
      check("tie_second_i", 64'(order_q[1]), 64'd1);
    end
    check("tie_done_gap", 64'(t_i_done - t_d_done), 64'(LAT + 2));

    // Continuous re-requests from both sides
    order_q.delete();
    maxlat = 0;
    fork
      for (int n = 0; n < 3; n++) begin
        d_issue(1'b0, 8'(8'h40 + n), 64'h0, ld);
        if (ld > maxlat) maxlat = ld;
      end
      for (int n = 0; n < 3; n++) begin
        i_issue(8'(8'h50 + n), li);
        if (li > maxlat) maxlat = li;
      end
    join
    ord = '0;
    foreach (order_q[k]) ord = {ord[4:0], order_q[k][0]};
    check("rr_count", 64'(order_q.size()), 64'd6);
    check("rr_order", 64'(ord), 64'b010101);
    check("rr_max_wait_ok", 64'(maxlat <= 2 * LAT + 3), 64'd1);

    // LAT=1 icache back-to-back reads
    for (int n = 1; n <= 3; n++) begin
      bit seen;
      int nb;
      bus1.i_addr = 8'(n); bus1.i_req = 1'b1;
      iq1.push_back(pat(8'(n)));
      seen = 1'b0; nb = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        nb += int'(bus1.sram_state == 2'd1);
        seen = bus1.i_done;
      end
      bus1.i_req = 1'b0;
      if (!seen) check("l1_timeout", 64'(seen), 64'd1);
      t1.push_back(cyc);
      check("l1_busy_cycles", 64'(nb), 64'd1);
      @(negedge clk);
    end
    if (t1.size() == 3) begin
      check("l1_period_a", 64'(t1[1] - t1[0]), 64'd3);
      check("l1_period_b", 64'(t1[2] - t1[1]), 64'd3);
    end

    repeat (3) @(negedge clk);
    check("grant_exclusive", 64'(both_cnt), 64'd0);
    check("no_spurious_done", 64'(spurious), 64'd0);
    check("queues_drained", 64'(dq.size() + iq.size() + iq1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
